// File: rtl/tenv_clockmeter_if.sv
// Bundle of measurement controls, expected timing and results for tenv_clockmeter.
// The bench drives through master; the meter attaches as slave.
interface tenv_clockmeter_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 en;
  logic                 clr;
  logic                 sig_in;
  logic [CNT_WIDTH-1:0] exp_high;
  logic [CNT_WIDTH-1:0] exp_low;
  logic [CNT_WIDTH-1:0] tol;
  logic [CNT_WIDTH-1:0] high_cnt;
  logic [CNT_WIDTH-1:0] low_cnt;
  logic                 meas_valid;
  logic                 err_high;
  logic                 err_low;
  logic                 err_stuck;

  modport master (
    output en, clr, sig_in, exp_high, exp_low, tol,
    input  high_cnt, low_cnt, meas_valid, err_high, err_low, err_stuck
  );

  modport slave (
    input  en, clr, sig_in, exp_high, exp_low, tol,
    output high_cnt, low_cnt, meas_valid, err_high, err_low, err_stuck
  );
endinterface

// File: rtl/tenv_clockmeter.sv
// Measures high/low phases of an asynchronous monitored clock in reference-clock
// cycles, publishes each complete period and keeps sticky tolerance/stuck flags.
module tenv_clockmeter #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  tenv_clockmeter_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PRIME,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   hcap_q;
  logic [CNT_WIDTH-1:0]   high_q, low_q;
  logic                   meas_valid_q;
  logic                   err_high_q, err_low_q, err_stuck_q;

  logic                   s, rise, fall, sat, in_meas, publish, stuck;
  logic [CNT_WIDTH:0]     high_diff, low_diff;
  logic                   high_bad, low_bad;

  always_comb begin
    s       = sync_q[SYNC_STAGES-1];
    rise    = s & ~s_d_q;
    fall    = ~s & s_d_q;
    sat     = (cnt_q == CNT_MAX);
    in_meas = (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);
    // Saturation outranks a coincident edge: a phase of 2^CNT_WIDTH-1 is never published.
    stuck   = bus.en && in_meas && sat;
    publish = bus.en && (state_q == MEAS_LOW) && rise && !sat;

    if (rise || fall) begin
      cnt_d = CNT_ONE;
    end else if (sat) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (hcap_q >= bus.exp_high) begin
      high_diff = {1'b0, hcap_q} - {1'b0, bus.exp_high};
    end else begin
      high_diff = {1'b0, bus.exp_high} - {1'b0, hcap_q};
    end
    if (cnt_q >= bus.exp_low) begin
      low_diff = {1'b0, cnt_q} - {1'b0, bus.exp_low};
    end else begin
      low_diff = {1'b0, bus.exp_low} - {1'b0, cnt_q};
    end
    high_bad = high_diff > {1'b0, bus.tol};
    low_bad  = low_diff  > {1'b0, bus.tol};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      s_d_q        <= 1'b0;
      cnt_q        <= '0;
      hcap_q       <= '0;
      high_q       <= '0;
      low_q        <= '0;
      meas_valid_q <= 1'b0;
      err_high_q   <= 1'b0;
      err_low_q    <= 1'b0;
      err_stuck_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      s_d_q        <= s;
      cnt_q        <= cnt_d;
      meas_valid_q <= publish;

      // A set in the same cycle as clr wins.
      err_high_q  <= (err_high_q  & ~bus.clr) | (publish & high_bad);
      err_low_q   <= (err_low_q   & ~bus.clr) | (publish & low_bad);
      err_stuck_q <= (err_stuck_q & ~bus.clr) | stuck;

      if (publish) begin
        high_q <= hcap_q;
        low_q  <= cnt_q;
      end

      if (!bus.en) begin
        state_q <= IDLE;
      end else if (stuck) begin
        state_q <= ARM;
      end else begin
        case (state_q)
          IDLE:      state_q <= ARM;
          ARM:       if (fall) state_q <= PRIME;
          PRIME:     if (rise) state_q <= MEAS_HIGH;
          MEAS_HIGH: begin
            if (fall) begin
              hcap_q  <= cnt_q;
              state_q <= MEAS_LOW;
            end
          end
          MEAS_LOW:  if (rise) state_q <= MEAS_HIGH;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.high_cnt   = high_q;
  assign bus.low_cnt    = low_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.err_high   = err_high_q;
  assign bus.err_low    = err_low_q;
  assign bus.err_stuck  = err_stuck_q;

endmodule

// File: tb/tb_tenv_clockmeter.sv
// Directed bench for tenv_clockmeter: phase-level reference model compared every
// cycle, plus literal expectations on published counts and flags.
module tb_tenv_clockmeter;
  localparam int unsigned CW   = 4;
  localparam int unsigned SS   = 2;
  localparam int          MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  tenv_clockmeter_if #(.CNT_WIDTH(CW)) bus ();

  tenv_clockmeter #(.CNT_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: follows the synchronized level stream, tracks how long the
  // current level has lasted and which phases count towards a publishable period.
  int m_sync [SS];
  int m_sd, m_run, m_hlen, m_cur, m_dh, m_dl;
  bit m_armed, m_primed, m_hi_ok, m_have_high;
  bit m_rise, m_fall, m_set_h, m_set_l, m_set_s;
  int m_hc, m_lc;
  bit m_mv, m_eh, m_el, m_es;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SS; i++) m_sync[i] = 0;
      m_sd = 0; m_run = 0; m_hlen = 0;
      m_armed = 0; m_primed = 0; m_hi_ok = 0; m_have_high = 0;
      m_hc = 0; m_lc = 0; m_mv = 0; m_eh = 0; m_el = 0; m_es = 0;
    end else begin
      m_cur = m_sync[SS-1];
      m_rise = (m_cur == 1) && (m_sd == 0);
      m_fall = (m_cur == 0) && (m_sd == 1);
      m_set_h = 0; m_set_l = 0; m_set_s = 0;
      m_mv = 0;
      if (!bus.en) begin
        m_armed = 0; m_primed = 0; m_hi_ok = 0; m_have_high = 0;
      end else if (!m_armed) begin
        m_armed = 1;
      end else if ((m_hi_ok || m_have_high) && m_run == MAXC) begin
        m_set_s = 1; m_primed = 0; m_hi_ok = 0; m_have_high = 0;
      end else begin
        if (m_fall) begin
          if (m_hi_ok) begin
            m_hlen = m_run; m_have_high = 1; m_hi_ok = 0;
          end
          m_primed = 1;
        end
        if (m_rise && m_primed) begin
          if (m_have_high) begin
            m_mv = 1; m_hc = m_hlen; m_lc = m_run;
            m_dh = m_hlen - int'(bus.exp_high); if (m_dh < 0) m_dh = -m_dh;
            m_dl = m_run  - int'(bus.exp_low);  if (m_dl < 0) m_dl = -m_dl;
            m_set_h = m_dh > int'(bus.tol);
            m_set_l = m_dl > int'(bus.tol);
          end
          m_have_high = 0; m_hi_ok = 1;
        end
      end
      m_eh = m_set_h | (m_eh & !bus.clr);
      m_el = m_set_l | (m_el & !bus.clr);
      m_es = m_set_s | (m_es & !bus.clr);
      if (m_cur != m_sd) m_run = 1;
      else if (m_run < MAXC) m_run++;
      m_sd = m_cur;
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = int'(bus.sig_in);
    end
  end

  always @(negedge clk) begin
    check("meas_valid", int'(bus.meas_valid), int'(m_mv));
    check("high_cnt",   int'(bus.high_cnt),   m_hc);
    check("low_cnt",    int'(bus.low_cnt),    m_lc);
    check("err_high",   int'(bus.err_high),   int'(m_eh));
    check("err_low",    int'(bus.err_low),    int'(m_el));
    check("err_stuck",  int'(bus.err_stuck),  int'(m_es));
  end

  int pub_n = 0, last_h = 0, last_l = 0;
  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      pub_n++;
      last_h = int'(bus.high_cnt);
      last_l = int'(bus.low_cnt);
    end
  end

  task automatic phase(input logic lvl, input int n);
    bus.sig_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      phase(1'b1, h);
      phase(1'b0, l);
    end
  endtask

  task automatic clr_low(input int l);
    bus.clr = 1'b1;
    phase(1'b0, l);
    bus.clr = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0; bus.sig_in = 1'b0;
    bus.exp_high = 4'd5; bus.exp_low = 4'd3; bus.tol = 4'd0;
    repeat (3) @(posedge clk); #1;
    check("rst_high_cnt",  int'(bus.high_cnt), 0);
    check("rst_meas_valid", int'(bus.meas_valid), 0);
    check("rst_err_stuck", int'(bus.err_stuck), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Nominal 5/3 clock: priming then one publish per period.
    bus.en = 1'b1;
    base = pub_n;
    run(5, 3, 6);
    check("prime_pubs", pub_n - base, 4);
    check("nom_high", last_h, 5);
    check("nom_low", last_l, 3);
    check("nom_err_high", int'(bus.err_high), 0);

    // One long high phase, then sticky error and clear.
    run(7, 3, 1);
    run(5, 3, 1);
    check("long_high", last_h, 7);
    check("long_err_high", int'(bus.err_high), 1);
    check("long_err_low", int'(bus.err_low), 0);
    run(5, 3, 2);
    check("sticky_err_high", int'(bus.err_high), 1);
    check("sticky_last_high", last_h, 5);
    phase(1'b1, 5);
    clr_low(3);
    check("clr_err_high", int'(bus.err_high), 0);

    // Tolerance boundary: deviation equal to tol passes, one beyond fails.
    bus.tol = 4'd2;
    run(7, 3, 3);
    check("tol2_err_high", int'(bus.err_high), 0);
    check("tol2_high", last_h, 7);
    bus.tol = 4'd1;
    run(7, 3, 2);
    check("tol1_err_high", int'(bus.err_high), 1);
    phase(1'b1, 5);
    clr_low(3);
    run(5, 5, 3);
    check("low_err_low", int'(bus.err_low), 1);
    check("low_err_high", int'(bus.err_high), 0);
    check("low_len", last_l, 5);
    bus.tol = 4'd0;
    phase(1'b1, 5);
    clr_low(3);
    check("clr_err_low", int'(bus.err_low), 0);

    // Stuck-high monitored clock saturates the counter.
    run(5, 3, 1);
    base = pub_n;
    phase(1'b1, 20);
    check("stuck_prev_pub", pub_n - base, 1);
    check("stuck_flag", int'(bus.err_stuck), 1);
    base = pub_n;
    phase(1'b0, 3);
    run(5, 3, 1);
    check("stuck_no_pub", pub_n - base, 0);
    run(5, 3, 2);
    check("stuck_resume", pub_n - base, 2);
    check("stuck_resume_high", last_h, 5);
    phase(1'b1, 5);
    clr_low(3);
    check("clr_err_stuck", int'(bus.err_stuck), 0);

    // Enable dropped during a low phase.
    run(5, 3, 2);
    phase(1'b1, 5);
    phase(1'b0, 3);
    bus.en = 1'b0;
    phase(1'b0, 2);
    base = pub_n;
    run(5, 3, 2);
    check("en_off_no_pub", pub_n - base, 0);
    check("en_off_high_cnt", int'(bus.high_cnt), 5);
    check("en_off_low_cnt", int'(bus.low_cnt), 3);
    bus.en = 1'b1;
    run(5, 3, 2);
    check("rearm_wait", pub_n - base, 0);
    run(5, 3, 1);
    check("rearm_pub", pub_n - base, 1);

    // Reset in the middle of a high phase with err_low set.
    bus.exp_low = 4'd2;
    run(5, 3, 2);
    phase(1'b1, 4);
    check("pre_rst_err_low", int'(bus.err_low), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_err_low", int'(bus.err_low), 0);
    check("mid_rst_high_cnt", int'(bus.high_cnt), 0);
    check("mid_rst_low_cnt", int'(bus.low_cnt), 0);
    phase(1'b1, 3);
    rst = 1'b0;
    bus.exp_low = 4'd3;
    phase(1'b1, 2);
    phase(1'b0, 3);
    base = pub_n;
    run(5, 3, 3);
    check("post_rst_pubs", pub_n - base, 2);
    check("post_rst_low", last_l, 3);
    check("post_rst_err_low", int'(bus.err_low), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
